pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipelined core (IF, ID, EX, MEM, WB).
- Generates per-stage register enables and bubble/flush strobes for:
  - load-use hazards,
  - taken branches resolved in EX,
  - jumps resolved in ID,
  - multi-cycle data-memory accesses with a parametrised wait latency.
- Keeps saturating stall and flush performance counters.
- Replaces the single global `enable` on the pipeline registers.

Parameters:
- REG_ADDR_W, 5: register-file address width.
- MEM_LAT, 2: data-memory wait cycles per MEM-stage access. Legal range 0..15; 0 means single-cycle memory.
- CNT_W, 32: width of the performance counters.

Ports:
- clk, input, 1: main clock, rising edge.
- rst, input, 1: synchronous reset, active-high.
- enable, input, 1: global run; 0 freezes everything.
- id_rs, input, REG_ADDR_W: rs field of the instruction in ID.
- id_rt, input, REG_ADDR_W: rt field of the instruction in ID.
- id_uses_rt, input, 1: the ID instruction reads rt.
- ex_mem_read, input, 1: the EX instruction is a load.
- ex_rd, input, REG_ADDR_W: destination register of the EX instruction.
- ex_branch_taken, input, 1: taken branch resolved in EX.
- id_jump, input, 1: jump decoded in ID.
- mem_access, input, 1: a valid load/store is in MEM.
- pc_en, output, 1: PC register enable.
- if_id_en, output, 1: IF/ID pipeline register enable.
- id_ex_en, output, 1: ID/EX pipeline register enable.
- ex_mem_en, output, 1: EX/MEM pipeline register enable.
- mem_wb_en, output, 1: MEM/WB pipeline register enable.
- if_id_flush, output, 1: load a NOP into IF/ID on the next edge.
- id_ex_flush, output, 1: load zero control (bubble) into ID/EX on the next edge.
- mem_busy, output, 1: controller is in the WAIT state.
- stall_cnt, output, CNT_W: cycles in which pc_en=0 while enable=1.
- flush_cnt, output, CNT_W: cycles in which either flush output was asserted.

Behaviour:
- State machine:
  - Two states: RUN and WAIT.
  - 4-bit wait_cnt register.
  - All outputs are combinational from state, wait_cnt and inputs.
  - State and counters are registered.
- Reset (rst=1, synchronous):
  - Next state RUN, wait_cnt=0, stall_cnt=0, flush_cnt=0.
  - While rst=1, all enables and flushes are 0 and mem_busy=0.
  - rst takes priority over every other event, including mid-WAIT: the in-flight access is abandoned.
- enable=0 (and rst=0):
  - All enables and flushes are 0.
  - State, wait_cnt and counters hold.
- Freeze cycle:
  - All five enables are 0 and both flushes are 0.
  - Branch, jump and hazard inputs are ignored.
- Freeze entry:
  - Condition: RUN with mem_access=1 and MEM_LAT>0.
  - Action: freeze, wait_cnt<=MEM_LAT-1, state<=WAIT.
- WAIT with wait_cnt>0: freeze, wait_cnt decrements.
- WAIT with wait_cnt==0:
  - Release cycle: decode as normal RUN, treating mem_access as 0.
  - state<=RUN.
  - The access therefore completes after exactly MEM_LAT frozen cycles.
- MEM_LAT=0: WAIT is never entered.
- Normal decode (RUN, or the WAIT release cycle), priority high to low:
  1. ex_branch_taken:
     - if_id_flush=1, id_ex_flush=1.
     - All enables 1.
     - Overrides a simultaneous load-use hazard and jump.
  2. Load-use hazard, defined as ex_mem_read && ex_rd!=0 && (ex_rd==id_rs || (id_uses_rt && ex_rd==id_rt)):
     - pc_en=0, if_id_en=0, id_ex_flush=1.
     - id_ex_en, ex_mem_en and mem_wb_en are 1.
     - One cycle only; clears naturally once the load advances.
     - A jump in ID during the hazard is deferred to the next cycle.
  3. id_jump:
     - if_id_flush=1.
     - All enables 1.
  4. Otherwise: all enables 1, no flush.
- mem_busy=1 iff state==WAIT (including the release cycle).
- Counters:
  - stall_cnt increments when enable=1, rst=0 and pc_en=0; covers freeze and load-use cycles.
  - flush_cnt increments when either flush output is asserted.
  - Both saturate at all-ones and never wrap.
- mem_access asserted in the release cycle is the same access and is ignored. A new access needs the MEM register to advance first.

Test Plan:
- Reset, then enable=1 with no hazards: all enables 1, flushes 0, counters stay 0 for 10 cycles.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs=5.
  - One cycle: pc_en=0, if_id_en=0, id_ex_flush=1.
  - stall_cnt=1, flush_cnt=1.
  - Repeat with ex_rd=0: no stall.
- MEM_LAT=3, mem_access=1 held:
  - Exactly 3 freeze cycles with mem_busy=1, then a release cycle with all enables 1.
  - stall_cnt=3. The following RUN cycle does not re-enter WAIT.
- Simultaneous ex_branch_taken + load-use hazard + id_jump: both flushes 1, all enables 1, flush_cnt +1 only.
- rst asserted during the second WAIT cycle:
  - Next cycle state RUN, mem_busy=0, counters 0.
  - With MEM_LAT=0, mem_access=1 causes no freeze.
- Saturation, using CNT_W=4 build: 20 load-use stalls give stall_cnt=15 and it holds. enable=0 mid-stall: all outputs 0 and counters hold.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage core: per-stage register enables,
// bubble/flush strobes, multi-cycle memory freeze and saturating performance counters.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int MEM_LAT    = 2,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_branch_taken,
    input  logic                  id_jump,
    input  logic                  mem_access,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  id_ex_en,
    output logic                  ex_mem_en,
    output logic                  mem_wb_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  mem_busy,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;
    localparam bit         HAS_WAIT = (MEM_LAT > 0);
    localparam logic [3:0] LAT_M1   = (MEM_LAT > 0) ? 4'(MEM_LAT - 1) : 4'd0;

    logic [0:0] state, state_nxt;
    logic [3:0] wait_cnt, wait_cnt_nxt;
    logic       load_use;
    logic       stall_inc;
    logic       flush_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        mem_busy     = !rst && (state == ST_WAIT);
        if (!rst && enable) begin
            if ((state == ST_WAIT) && (wait_cnt != 4'd0)) begin
                wait_cnt_nxt = wait_cnt - 4'd1;
            end else if ((state == ST_RUN) && mem_access && HAS_WAIT) begin
                wait_cnt_nxt = LAT_M1;
                state_nxt    = ST_WAIT;
            end else begin
                // Release cycle falls through here too; its mem_access is the finished access.
                state_nxt = ST_RUN;
                pc_en     = 1'b1;
                if_id_en  = 1'b1;
                id_ex_en  = 1'b1;
                ex_mem_en = 1'b1;
                mem_wb_en = 1'b1;
                if (ex_branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end else if (id_jump) begin
                    if_id_flush = 1'b1;
                end
            end
        end
    end

    assign stall_inc = enable && !rst && !pc_en;
    assign flush_inc = if_id_flush || id_ex_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            wait_cnt  <= 4'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (stall_inc) stall_cnt <= sat_inc(stall_cnt);
            if (flush_inc) flush_cnt <= sat_inc(flush_cnt);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: three builds (MEM_LAT=3, MEM_LAT=0, CNT_W=4)
// share one stimulus and each scenario task checks the build it targets.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst, enable;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_uses_rt, ex_mem_read, ex_branch_taken, id_jump, mem_access;

    logic [4:0]  en_a, en_z, en_s;
    logic [1:0]  fl_a, fl_z, fl_s;
    logic        busy_a, busy_z, busy_s;
    logic [31:0] stall_a, flush_a, stall_z, flush_z;
    logic [3:0]  stall_s, flush_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .MEM_LAT(3), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken), .id_jump(id_jump), .mem_access(mem_access),
        .pc_en(en_a[4]), .if_id_en(en_a[3]), .id_ex_en(en_a[2]), .ex_mem_en(en_a[1]),
        .mem_wb_en(en_a[0]), .if_id_flush(fl_a[1]), .id_ex_flush(fl_a[0]),
        .mem_busy(busy_a), .stall_cnt(stall_a), .flush_cnt(flush_a));

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .MEM_LAT(0), .CNT_W(32)) u_lat0 (
        .clk(clk), .rst(rst), .enable(enable), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken), .id_jump(id_jump), .mem_access(mem_access),
        .pc_en(en_z[4]), .if_id_en(en_z[3]), .id_ex_en(en_z[2]), .ex_mem_en(en_z[1]),
        .mem_wb_en(en_z[0]), .if_id_flush(fl_z[1]), .id_ex_flush(fl_z[0]),
        .mem_busy(busy_z), .stall_cnt(stall_z), .flush_cnt(flush_z));

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .MEM_LAT(2), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .enable(enable), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken), .id_jump(id_jump), .mem_access(mem_access),
        .pc_en(en_s[4]), .if_id_en(en_s[3]), .id_ex_en(en_s[2]), .ex_mem_en(en_s[1]),
        .mem_wb_en(en_s[0]), .if_id_flush(fl_s[1]), .id_ex_flush(fl_s[0]),
        .mem_busy(busy_s), .stall_cnt(stall_s), .flush_cnt(flush_s));

    // Inputs change 1ns after a rising edge; outputs are sampled 2ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
        id_uses_rt = 1'b0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
        id_jump = 1'b0; mem_access = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        rst = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; idle_inputs();
        mem_access = 1'b1; ex_branch_taken = 1'b1;
        settle();
        total++; if (en_a !== 5'b00000) begin bad++; $display("FAIL reset_en got=%b exp=%b", en_a, 5'b00000); end
        total++; if (fl_a !== 2'b00) begin bad++; $display("FAIL reset_flush got=%b exp=%b", fl_a, 2'b00); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
        tick();
        rst = 1'b0; idle_inputs();
        settle();
        total++; if (stall_a !== 32'd0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", stall_a); end
        total++; if (flush_a !== 32'd0) begin bad++; $display("FAIL reset_flushcnt got=%0d exp=0", flush_a); end
    endtask

    task automatic test_idle();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            settle();
            total++; if (en_a !== 5'b11111 || fl_a !== 2'b00) begin
                bad++; $display("FAIL idle_cycle%0d en=%b fl=%b exp en=11111 fl=00", i, en_a, fl_a);
            end
            tick();
        end
        total++; if (stall_a !== 32'd0 || flush_a !== 32'd0) begin
            bad++; $display("FAIL idle_counters stall=%0d flush=%0d exp 0/0", stall_a, flush_a);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
        settle();
        total++; if (en_a !== 5'b00111) begin bad++; $display("FAIL lu_rs_en got=%b exp=00111", en_a); end
        total++; if (fl_a !== 2'b01) begin bad++; $display("FAIL lu_rs_flush got=%b exp=01", fl_a); end
        tick();
        idle_inputs();
        settle();
        total++; if (stall_a !== 32'd1 || flush_a !== 32'd1) begin
            bad++; $display("FAIL lu_counters stall=%0d flush=%0d exp 1/1", stall_a, flush_a);
        end
        // Destination r0 never creates a hazard.
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0;
        settle();
        total++; if (en_a !== 5'b11111 || fl_a !== 2'b00) begin
            bad++; $display("FAIL lu_r0 en=%b fl=%b exp 11111/00", en_a, fl_a);
        end
        tick();
        // rt match only counts when the instruction reads rt.
        ex_rd = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_uses_rt = 1'b0;
        settle();
        total++; if (en_a !== 5'b11111) begin bad++; $display("FAIL lu_rt_unused got=%b exp=11111", en_a); end
        id_uses_rt = 1'b1;
        settle();
        total++; if (en_a !== 5'b00111) begin bad++; $display("FAIL lu_rt_used got=%b exp=00111", en_a); end
        // Jump under a hazard is deferred.
        id_jump = 1'b1;
        settle();
        total++; if (fl_a !== 2'b01) begin bad++; $display("FAIL lu_jump_deferred got=%b exp=01", fl_a); end
        tick();
        ex_mem_read = 1'b0;
        settle();
        total++; if (fl_a !== 2'b10 || en_a !== 5'b11111) begin
            bad++; $display("FAIL jump_after_lu fl=%b en=%b exp 10/11111", fl_a, en_a);
        end
        tick();
        idle_inputs();
        settle();
        total++; if (stall_a !== 32'd2 || flush_a !== 32'd3) begin
            bad++; $display("FAIL lu_totals stall=%0d flush=%0d exp 2/3", stall_a, flush_a);
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_access = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ex_branch_taken = (i == 1);
            settle();
            total++; if (en_a !== 5'b00000 || fl_a !== 2'b00) begin
                bad++; $display("FAIL wait_freeze%0d en=%b fl=%b exp 00000/00", i, en_a, fl_a);
            end
            total++; if (busy_a !== (i > 0)) begin
                bad++; $display("FAIL wait_busy%0d got=%b exp=%b", i, busy_a, (i > 0));
            end
            tick();
        end
        ex_branch_taken = 1'b0;
        settle();
        total++; if (en_a !== 5'b11111 || busy_a !== 1'b1) begin
            bad++; $display("FAIL wait_release en=%b busy=%b exp 11111/1", en_a, busy_a);
        end
        tick();
        mem_access = 1'b0;
        settle();
        total++; if (en_a !== 5'b11111 || busy_a !== 1'b0) begin
            bad++; $display("FAIL wait_after en=%b busy=%b exp 11111/0", en_a, busy_a);
        end
        total++; if (stall_a !== 32'd3 || flush_a !== 32'd0) begin
            bad++; $display("FAIL wait_counters stall=%0d flush=%0d exp 3/0", stall_a, flush_a);
        end
        tick();
    endtask

    task automatic test_priority();
        do_reset();
        ex_branch_taken = 1'b1; id_jump = 1'b1;
        ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs = 5'd9;
        settle();
        total++; if (en_a !== 5'b11111 || fl_a !== 2'b11) begin
            bad++; $display("FAIL prio_branch en=%b fl=%b exp 11111/11", en_a, fl_a);
        end
        tick();
        idle_inputs();
        settle();
        total++; if (flush_a !== 32'd1 || stall_a !== 32'd0) begin
            bad++; $display("FAIL prio_counters flush=%0d stall=%0d exp 1/0", flush_a, stall_a);
        end
    endtask

    task automatic test_rst_mid_wait();
        do_reset();
        mem_access = 1'b1;
        tick();
        tick();
        settle();
        total++; if (busy_a !== 1'b1 || stall_a !== 32'd2) begin
            bad++; $display("FAIL rstw_pre busy=%b stall=%0d exp 1/2", busy_a, stall_a);
        end
        rst = 1'b1;
        settle();
        total++; if (busy_a !== 1'b0 || en_a !== 5'b00000) begin
            bad++; $display("FAIL rstw_during busy=%b en=%b exp 0/00000", busy_a, en_a);
        end
        tick();
        rst = 1'b0; mem_access = 1'b0;
        settle();
        total++; if (busy_a !== 1'b0 || en_a !== 5'b11111 || stall_a !== 32'd0 || flush_a !== 32'd0) begin
            bad++; $display("FAIL rstw_after busy=%b en=%b stall=%0d flush=%0d exp 0/11111/0/0",
                            busy_a, en_a, stall_a, flush_a);
        end
        mem_access = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            total++; if (en_z !== 5'b11111 || fl_z !== 2'b00 || busy_z !== 1'b0) begin
                bad++; $display("FAIL lat0_cycle%0d en=%b fl=%b busy=%b exp 11111/00/0", i, en_z, fl_z, busy_z);
            end
            tick();
        end
        mem_access = 1'b0;
        settle();
        total++; if (stall_z !== 32'd0 || flush_z !== 32'd0) begin
            bad++; $display("FAIL lat0_counters stall=%0d flush=%0d exp 0/0", stall_z, flush_z);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        ex_mem_read = 1'b1; ex_rd = 5'd4; id_rs = 5'd4;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 13 || i == 14 || i == 19) begin
                settle();
                total++; if (stall_s !== ((i == 13) ? 4'd14 : 4'd15)) begin
                    bad++; $display("FAIL sat_stall_i%0d got=%0d exp=%0d", i, stall_s, (i == 13) ? 14 : 15);
                end
            end
        end
        total++; if (flush_s !== 4'd15 || stall_a !== 32'd20) begin
            bad++; $display("FAIL sat_other flush_s=%0d stall_a=%0d exp 15/20", flush_s, stall_a);
        end
        enable = 1'b0;
        settle();
        total++; if (en_s !== 5'b00000 || fl_s !== 2'b00 || busy_s !== 1'b0 || en_a !== 5'b00000 || fl_a !== 2'b00) begin
            bad++; $display("FAIL dis_outputs en_s=%b fl_s=%b busy_s=%b en_a=%b fl_a=%b exp all 0",
                            en_s, fl_s, busy_s, en_a, fl_a);
        end
        tick();
        tick();
        settle();
        total++; if (stall_a !== 32'd20 || flush_a !== 32'd20 || stall_s !== 4'd15) begin
            bad++; $display("FAIL dis_hold stall_a=%0d flush_a=%0d stall_s=%0d exp 20/20/15",
                            stall_a, flush_a, stall_s);
        end
        enable = 1'b1;
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0;
        idle_inputs();
        tick();
        tick();
        test_reset();
        test_idle();
        test_load_use();
        test_mem_wait();
        test_priority();
        test_rst_mid_wait();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
